layer_priority_mux: RTL and testbench

Parametrised N-layer pixel compositor with a two-stage pipeline. It sits between the per-object drawing units and the VGA output stage.
- Each cycle it selects the highest-priority enabled layer asserting a drawing request; the background pixel is used when no layer requests.
- It also accumulates per-frame overlap (collision) flags for game logic.
- A run-time layer-enable mask lets layers be blanked without touching their drawing units.

---
 rtl/layer_mux_pkg.sv | 22 ++
 rtl/layer_priority_mux_prio_encoder.sv | 28 ++
 rtl/layer_priority_mux.sv | 129 ++++++++++++
 tb/tb_layer_priority_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer_mux_pkg.sv
// Shared types and helpers for the layer priority compositor.
// rgb_t is the default 8-bit pixel type; popcount_ge2 detects overlapping requests.
package layer_mux_pkg;

    localparam int unsigned RGB_W_DEFAULT = 8;
    localparam int unsigned MAX_LAYERS    = 64;

    typedef logic [RGB_W_DEFAULT-1:0] rgb_t;

    // The background winner code is one past the last layer index.
    function automatic int unsigned bg_winner_code(input int unsigned num_layers);
        return num_layers;
    endfunction

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic popcount_ge2(input logic [MAX_LAYERS-1:0] v);
        logic [MAX_LAYERS-1:0] one_v;
        one_v = MAX_LAYERS'(1'b1);
        return |(v & (v - one_v));
    endfunction

endpackage

// File: rtl/layer_priority_mux_prio_encoder.sv
// Combinational lowest-index-first encoder: found flag, binary index and one-hot grant.
// With no request the index reports NUM_LAYERS (the background code).
module prio_encoder #(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned IDX_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic [NUM_LAYERS-1:0] i_req,
    output logic                  o_found,
    output logic [IDX_W-1:0]      o_index,
    output logic [NUM_LAYERS-1:0] o_grant
);

    localparam logic [NUM_LAYERS-1:0] LSB_ONE = NUM_LAYERS'(1'b1);

    logic [IDX_W-1:0] w_index_raw;

    // Isolate the lowest set request bit, then fold it into a binary index.
    always_comb begin
        o_grant     = i_req & (~i_req + LSB_ONE);
        o_found     = |i_req;
        w_index_raw = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_index_raw = w_index_raw | (IDX_W'(i) & {IDX_W{o_grant[i]}});
        end
        o_index = o_found ? w_index_raw : IDX_W'(NUM_LAYERS);
    end

endmodule

// File: rtl/layer_priority_mux.sv
// Two-stage N-layer pixel compositor with run-time enable mask and per-frame collision flags.
// Optional colour keying is compiled in with the LAYER_MUX_COLORKEY_EN macro.
module layer_priority_mux
    import layer_mux_pkg::*;
#(
    parameter int unsigned       NUM_LAYERS = 8,
    parameter int unsigned       RGB_W      = 8,
    parameter logic [RGB_W-1:0]  COLOR_KEY  = 8'hFF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_LAYERS-1:0]                draw_req,
    input  logic [NUM_LAYERS*RGB_W-1:0]          layer_rgb,
    input  logic [RGB_W-1:0]                     bg_rgb,
    input  logic                                 frame_start,
    input  logic                                 mask_wr,
    input  logic [NUM_LAYERS-1:0]                mask_data,
    output logic [RGB_W-1:0]                     rgb_out,
    output logic [$clog2(NUM_LAYERS+1)-1:0]      winner,
    output logic [NUM_LAYERS-1:0]                collision_frame,
    output logic                                 collision_valid
);

    localparam int unsigned      WIN_W   = $clog2(NUM_LAYERS + 1);
    localparam logic [WIN_W-1:0] BG_CODE = WIN_W'(bg_winner_code(NUM_LAYERS));
`ifdef LAYER_MUX_COLORKEY_EN
    localparam logic             KEY_EN  = 1'b1;
`else
    localparam logic             KEY_EN  = 1'b0;
`endif

    logic [NUM_LAYERS-1:0]       r_mask;
    logic [NUM_LAYERS-1:0]       w_key_ok;
    logic [NUM_LAYERS-1:0]       w_q;

    logic [NUM_LAYERS-1:0]       r_q;
    logic [NUM_LAYERS*RGB_W-1:0] r_rgb;
    logic [RGB_W-1:0]            r_bg;
    logic                        r_fs;

    logic                        w_found;
    logic [WIN_W-1:0]            w_index;
    logic [NUM_LAYERS-1:0]       w_grant;
    logic [RGB_W-1:0]            w_layer_rgb;
    logic [RGB_W-1:0]            w_pix_rgb;
    logic [NUM_LAYERS-1:0]       w_coll;

    logic [NUM_LAYERS-1:0]       r_acc;

    // A keyed (transparent) colour drops out of arbitration only when keying is compiled in.
    always_comb begin
        w_key_ok = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_key_ok[i] = (layer_rgb[i*RGB_W +: RGB_W] != COLOR_KEY) | ~KEY_EN;
        end
        w_q = draw_req & r_mask & w_key_ok;
    end

    // Layer enable mask; a write takes effect on the next presented pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '1;
        end else if (mask_wr) begin
            r_mask <= mask_data;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Stage 1: capture qualified requests, colours and frame marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            r_rgb <= '0;
            r_bg  <= '0;
            r_fs  <= 1'b0;
        end else begin
            r_q   <= w_q;
            r_rgb <= layer_rgb;
            r_bg  <= bg_rgb;
            r_fs  <= frame_start;
        end
    end

    prio_encoder #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (WIN_W)
    ) u_prio_encoder (
        .i_req   (r_q),
        .o_found (w_found),
        .o_index (w_index),
        .o_grant (w_grant)
    );

    // One-hot AND-OR select of the winning colour, falling back to background.
    always_comb begin
        w_layer_rgb = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_layer_rgb = w_layer_rgb | ({RGB_W{w_grant[i]}} & r_rgb[i*RGB_W +: RGB_W]);
        end
        w_pix_rgb = w_found ? w_layer_rgb : r_bg;
        w_coll    = popcount_ge2(MAX_LAYERS'(r_q)) ? r_q : '0;
    end

    // Stage 2: registered pixel outputs and collision accumulation with frame snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out         <= '0;
            winner          <= BG_CODE;
            collision_frame <= '0;
            collision_valid <= 1'b0;
            r_acc           <= '0;
        end else begin
            rgb_out <= w_pix_rgb;
            winner  <= w_found ? w_index : BG_CODE;
            if (r_fs) begin
                // The boundary pixel belongs to the new frame, so it seeds the accumulator.
                collision_frame <= r_acc;
                collision_valid <= 1'b1;
                r_acc           <= w_coll;
            end else begin
                collision_frame <= collision_frame;
                collision_valid <= 1'b0;
                r_acc           <= r_acc | w_coll;
            end
        end
    end

endmodule

// File: tb/tb_layer_priority_mux.sv
// Randomised bench for layer_priority_mux against a behavioural model, plus directed pinned cases.
module tb_layer_priority_mux;

    localparam int N = 8;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     draw_req;
    logic [N*W-1:0]   layer_rgb;
    logic [W-1:0]     bg_rgb;
    logic             frame_start;
    logic             mask_wr;
    logic [N-1:0]     mask_data;
    logic [W-1:0]     rgb_out;
    logic [3:0]       winner;
    logic [N-1:0]     collision_frame;
    logic             collision_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_priority_mux #(.NUM_LAYERS(N), .RGB_W(W), .COLOR_KEY(8'hFF)) dut (
        .clk             (clk),
        .reset           (reset),
        .draw_req        (draw_req),
        .layer_rgb       (layer_rgb),
        .bg_rgb          (bg_rgb),
        .frame_start     (frame_start),
        .mask_wr         (mask_wr),
        .mask_data       (mask_data),
        .rgb_out         (rgb_out),
        .winner          (winner),
        .collision_frame (collision_frame),
        .collision_valid (collision_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one pixel in flight, outputs computed from plain rules.
    typedef struct packed {
        logic [N-1:0]   q;
        logic [N*W-1:0] cols;
        logic [W-1:0]   bg;
        logic           fs;
    } pix_t;

    pix_t         d1;
    logic [N-1:0] m_mask;
    logic [N-1:0] m_acc;
    logic [W-1:0] exp_rgb;
    logic [3:0]   exp_win;
    logic [N-1:0] exp_cf;
    logic         exp_cv;
    logic         m_started = 1'b0;

    always @(posedge clk) begin
        int           w;
        logic [N-1:0] coll;
        if (reset) begin
            exp_rgb   = '0;
            exp_win   = 4'(N);
            exp_cf    = '0;
            exp_cv    = 1'b0;
            m_acc     = '0;
            m_mask    = '1;
            d1        = '0;
            m_started = 1'b1;
        end else begin
            w = N;
            for (int i = N - 1; i >= 0; i--) begin
                if (d1.q[i]) w = i;
            end
            exp_win = 4'(w);
            exp_rgb = (w == N) ? d1.bg : d1.cols[w*W +: W];
            coll    = ($countones(d1.q) >= 2) ? d1.q : '0;
            if (d1.fs) begin
                exp_cf = m_acc;
                exp_cv = 1'b1;
                m_acc  = coll;
            end else begin
                exp_cv = 1'b0;
                m_acc  = m_acc | coll;
            end
            d1.q    = draw_req & m_mask;
            d1.cols = layer_rgb;
            d1.bg   = bg_rgb;
            d1.fs   = frame_start;
            if (mask_wr) m_mask = mask_data;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("rgb_out", rgb_out, exp_rgb);
            check("winner", winner, exp_win);
            check("collision_frame", collision_frame, exp_cf);
            check("collision_valid", collision_valid, exp_cv);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic fs, input logic mw, input logic [N-1:0] md);
        draw_req    = req;
        frame_start = fs;
        mask_wr     = mw;
        mask_data   = md;
    endtask

    initial begin
        reset = 1'b1;
        layer_rgb = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'hE0, 8'h1C, 8'h11};
        bg_rgb = 8'h03;
        drive(8'h00, 1'b0, 1'b0, 8'h00);
        step();
        step();
        check("rst_rgb", rgb_out, 8'h00);
        check("rst_win", winner, 4'd8);
        check("rst_cf", collision_frame, 8'h00);
        check("rst_cv", collision_valid, 1'b0);
        reset = 1'b0;

        // Layers 1 and 2 request; layer 1 wins.
        drive(8'b0000_0110, 1'b0, 1'b0, 8'h00); step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("prio_rgb", rgb_out, 8'h1C);
        check("prio_win", winner, 4'd1);
        drive(8'h00, 1'b0, 1'b1, 8'hFD);        step();
        check("bg_rgb", rgb_out, 8'h03);
        check("bg_win", winner, 4'd8);
        drive(8'b0000_0110, 1'b0, 1'b0, 8'h00); step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("mask_rgb", rgb_out, 8'hE0);
        check("mask_win", winner, 4'd2);
        drive(8'h00, 1'b0, 1'b1, 8'hFF);        step();

        // Frame with the earlier 1/2 overlap, then a frame with a 0/3 overlap, then a clean frame.
        drive(8'h00, 1'b1, 1'b0, 8'h00);        step();
        drive(8'b0000_1001, 1'b0, 1'b0, 8'h00); step();
        check("snap0_cv", collision_valid, 1'b1);
        check("snap0_cf", collision_frame, 8'h06);
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        drive(8'h00, 1'b1, 1'b0, 8'h00);        step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("snap1_cv", collision_valid, 1'b1);
        check("snap1_cf", collision_frame, 8'b0000_1001);
        step();
        check("snap1_pulse", collision_valid, 1'b0);
        drive(8'h00, 1'b1, 1'b0, 8'h00);        step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("snap2_cf", collision_frame, 8'h00);

        // Overlap coincident with frame_start belongs to the new frame.
        drive(8'b0011_0000, 1'b1, 1'b0, 8'h00); step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("edge_cv", collision_valid, 1'b1);
        check("edge_cf", collision_frame, 8'h00);
        check("edge_rgb", rgb_out, 8'h44);
        drive(8'h00, 1'b1, 1'b0, 8'h00);        step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("edge_next_cf", collision_frame, 8'b0011_0000);

        // Key colour on layer 0 still wins when keying is not compiled in.
        layer_rgb[7:0]  = 8'hFF;
        layer_rgb[15:8] = 8'h55;
        drive(8'b0000_0011, 1'b0, 1'b0, 8'h00); step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("key_rgb", rgb_out, 8'hFF);
        check("key_win", winner, 4'd0);
        drive(8'h00, 1'b1, 1'b0, 8'h00);        step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("key_cf", collision_frame, 8'b0000_0011);

        // Reset mid-frame discards the accumulated collision.
        drive(8'b0000_0011, 1'b0, 1'b0, 8'h00); step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        reset = 1'b1;                            step();
        reset = 1'b0;
        check("mrst_win", winner, 4'd8);
        check("mrst_rgb", rgb_out, 8'h00);
        drive(8'h00, 1'b1, 1'b0, 8'h00);        step();
        drive(8'h00, 1'b0, 1'b0, 8'h00);        step();
        check("mrst_cv", collision_valid, 1'b1);
        check("mrst_cf", collision_frame, 8'h00);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [N-1:0] req;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       req = '0;
                1:       req = 8'(1 << $urandom_range(0, N - 1));
                default: req = 8'($urandom);
            endcase
            layer_rgb = {$urandom, $urandom};
            bg_rgb    = 8'($urandom);
            drive(req, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0), 8'($urandom));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 8'h00);
        step();
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
